// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: FU completion requests in, grants and
// registered CDB lanes out.
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 8,
  parameter int CDB_WIDTH = 4,
  parameter int TAG_W     = 7
);
  logic [NUM_REQ-1:0]       fu_req;
  logic [NUM_REQ*TAG_W-1:0] fu_tag;
  logic                     flush;
  logic [NUM_REQ-1:0]       fu_grant;
  logic [CDB_WIDTH-1:0]     cdb_pr_ready;
  logic [TAG_W-1:0]         cdb_pr_tag_0;
  logic [TAG_W-1:0]         cdb_pr_tag_1;
  logic [TAG_W-1:0]         cdb_pr_tag_2;
  logic [TAG_W-1:0]         cdb_pr_tag_3;

  modport master (
    output fu_req, fu_tag, flush,
    input  fu_grant, cdb_pr_ready,
    input  cdb_pr_tag_0, cdb_pr_tag_1,
    input  cdb_pr_tag_2, cdb_pr_tag_3
  );

  modport slave (
    input  fu_req, fu_tag, flush,
    output fu_grant, cdb_pr_ready,
    output cdb_pr_tag_0, cdb_pr_tag_1,
    output cdb_pr_tag_2, cdb_pr_tag_3
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with registered lanes.
// Define CDB_ARB_FIXED_PRI_EN for fixed lowest-index-first priority.
module cdb_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int CDB_WIDTH = 4,
  parameter int TAG_W     = 7
) (
  input  logic       clock,
  input  logic       reset,
  cdb_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
  localparam int CW = $clog2(CDB_WIDTH + 1);

  logic [TAG_W-1:0]     tag_a [NUM_REQ];
  logic [NUM_REQ-1:0]   grant_raw;
  logic [CDB_WIDTH-1:0] lane_v_d, lane_v_q;
  logic [TAG_W-1:0]     lane_tag_d [CDB_WIDTH];
  logic [TAG_W-1:0]     lane_tag_q [CDB_WIDTH];
  logic [TAG_W-1:0]     pad [4];
  logic [PW-1:0]        base, last, idx;
  logic [CW-1:0]        cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_tag
    assign tag_a[i] = bus.fu_tag[i*TAG_W +: TAG_W];
  end

  // k-th winner in scan order lands on lane k
  always_comb begin
    grant_raw = '0;
    last      = base;
    idx       = base;
    cnt       = '0;
    lane_v_d  = '0;
    for (int k = 0; k < CDB_WIDTH; k++) lane_tag_d[k] = '1;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = base + PW'(j);
      if (bus.fu_req[idx] && cnt < CW'(CDB_WIDTH)) begin
        grant_raw[idx]          = 1'b1;
        lane_v_d[cnt[LW-1:0]]   = 1'b1;
        lane_tag_d[cnt[LW-1:0]] = tag_a[idx];
        last = idx;
        cnt  = cnt + 1'b1;
      end
    end
    if (bus.flush) begin
      lane_v_d = '0;
      for (int k = 0; k < CDB_WIDTH; k++) lane_tag_d[k] = '1;
    end
  end

  assign bus.fu_grant = (reset || bus.flush) ? '0 : grant_raw;

`ifdef CDB_ARB_FIXED_PRI_EN
  assign base = '0;
`else
  logic [PW-1:0] rr_d, rr_q;

  assign base = rr_q;
  assign rr_d = (|bus.fu_grant) ? last + 1'b1 : rr_q;

  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_v_q <= '0;
      for (int k = 0; k < CDB_WIDTH; k++) lane_tag_q[k] <= '1;
    end else begin
      lane_v_q   <= lane_v_d;
      lane_tag_q <= lane_tag_d;
    end
  end

  // rob always sees four tag ports; unused lanes read as invalid tag
  for (genvar k = 0; k < 4; k++) begin : g_pad
    if (k < CDB_WIDTH) begin : g_on
      assign pad[k] = lane_tag_q[k];
    end else begin : g_off
      assign pad[k] = '1;
    end
  end

  assign bus.cdb_pr_ready = lane_v_q;
  assign bus.cdb_pr_tag_0 = pad[0];
  assign bus.cdb_pr_tag_1 = pad[1];
  assign bus.cdb_pr_tag_2 = pad[2];
  assign bus.cdb_pr_tag_3 = pad[3];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(8), .CDB_WIDTH(4), .TAG_W(7)) bus ();

  cdb_arbiter #(.NUM_REQ(8), .CDB_WIDTH(4), .TAG_W(7)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] req;
    logic       flush;
    logic [6:0] t2;
    logic [7:0] g;
    logic [3:0] rdy;
    logic [6:0] l0, l1, l2, l3;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_tags(input logic [6:0] t2);
    for (int i = 0; i < 8; i++)
      bus.fu_tag[i*7 +: 7] = (i == 2) ? t2 : 7'(i + 40);
  endtask

  task automatic chk_lanes(input string nm, input logic [3:0] rdy,
                           input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
    chk({nm, " ready"}, 64'(bus.cdb_pr_ready), 64'(rdy));
    chk({nm, " tag0"}, 64'(bus.cdb_pr_tag_0), 64'(a));
    chk({nm, " tag1"}, 64'(bus.cdb_pr_tag_1), 64'(b));
    chk({nm, " tag2"}, 64'(bus.cdb_pr_tag_2), 64'(c));
    chk({nm, " tag3"}, 64'(bus.cdb_pr_tag_3), 64'(d));
  endtask

  initial begin
    tv[0]  = '{8'hFF, 1'b0, 7'd42, 8'h0F, 4'hF, 7'd40, 7'd41, 7'd42, 7'd43};
    tv[1]  = '{8'hFF, 1'b0, 7'd42, 8'hF0, 4'hF, 7'd44, 7'd45, 7'd46, 7'd47};
    tv[2]  = '{8'hFF, 1'b0, 7'd42, 8'h0F, 4'hF, 7'd40, 7'd41, 7'd42, 7'd43};
    tv[3]  = '{8'h04, 1'b0, 7'd35, 8'h04, 4'h1, 7'd35, 7'h7f, 7'h7f, 7'h7f};
    tv[4]  = '{8'h00, 1'b0, 7'd42, 8'h00, 4'h0, 7'h7f, 7'h7f, 7'h7f, 7'h7f};
    tv[5]  = '{8'h20, 1'b0, 7'd42, 8'h20, 4'h1, 7'd45, 7'h7f, 7'h7f, 7'h7f};
    tv[6]  = '{8'hC3, 1'b0, 7'd42, 8'hC3, 4'hF, 7'd46, 7'd47, 7'd40, 7'd41};
    tv[7]  = '{8'h11, 1'b1, 7'd42, 8'h00, 4'h0, 7'h7f, 7'h7f, 7'h7f, 7'h7f};
    tv[8]  = '{8'h11, 1'b0, 7'd42, 8'h11, 4'h3, 7'd44, 7'd40, 7'h7f, 7'h7f};
    tv[9]  = '{8'hFE, 1'b0, 7'd42, 8'h1E, 4'hF, 7'd41, 7'd42, 7'd43, 7'd44};
    tv[10] = '{8'h03, 1'b0, 7'd42, 8'h03, 4'h3, 7'd40, 7'd41, 7'h7f, 7'h7f};
    tv[11] = '{8'hFF, 1'b0, 7'd42, 8'h3C, 4'hF, 7'd42, 7'd43, 7'd44, 7'd45};
    tv[12] = '{8'hFF, 1'b0, 7'd42, 8'hC3, 4'hF, 7'd46, 7'd47, 7'd40, 7'd41};

    rst        = 1'b1;
    bus.fu_req = 8'hFF;
    bus.flush  = 1'b0;
    set_tags(7'd42);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("reset%0d grant", c), 64'(bus.fu_grant), 64'h0);
    end
    @(posedge clk); #1;
    chk_lanes("reset", 4'h0, 7'h7f, 7'h7f, 7'h7f, 7'h7f);

    @(negedge clk);
    rst        = 1'b0;
    bus.fu_req = 8'h00;
    @(posedge clk); #1;

`ifdef CDB_ARB_FIXED_PRI_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.fu_req = 8'hFF;
      #1;
      chk($sformatf("fixed%0d grant", c), 64'(bus.fu_grant), 64'h0F);
      @(posedge clk); #1;
      chk_lanes($sformatf("fixed%0d", c), 4'hF,
                7'd40, 7'd41, 7'd42, 7'd43);
    end
`else
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.fu_req = tv[i].req;
      bus.flush  = tv[i].flush;
      set_tags(tv[i].t2);
      #1;
      chk($sformatf("v%0d grant", i), 64'(bus.fu_grant), 64'(tv[i].g));
      @(posedge clk); #1;
      chk_lanes($sformatf("v%0d", i), tv[i].rdy,
                tv[i].l0, tv[i].l1, tv[i].l2, tv[i].l3);
    end

    // reset mid-stream, together with flush, from rr_ptr=2
    @(negedge clk);
    bus.fu_req = 8'hFF;
    bus.flush  = 1'b0;
    set_tags(7'd42);
    #1;
    chk("mid pre grant", 64'(bus.fu_grant), 64'h3C);
    @(posedge clk); #1;
    chk_lanes("mid pre", 4'hF, 7'd42, 7'd43, 7'd44, 7'd45);

    @(negedge clk);
    rst       = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("mid rst grant", 64'(bus.fu_grant), 64'h0);
    @(posedge clk); #1;
    chk_lanes("mid rst", 4'h0, 7'h7f, 7'h7f, 7'h7f, 7'h7f);

    @(negedge clk);
    rst       = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("mid post grant", 64'(bus.fu_grant), 64'h0F);
    @(posedge clk); #1;
    chk_lanes("mid post", 4'hF, 7'd40, 7'd41, 7'd42, 7'd43);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
